// File: rtl/wb_arb_pkg.sv
// ============================================================================
// Module      : wb_arb_pkg
// Description : Shared types and constants for the Wishbone burst arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_SINGLE = 2'd1,
        ARB_BURST  = 2'd2,
        ARB_ABORT  = 2'd3
    } arb_state_e;

    localparam int BURST_BEATS = 4;

    // Width of a master index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_rr_picker.sv
// ============================================================================
// Module      : wb_rr_picker
// Description : Round-robin priority encoder: first request at or after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_rr_picker #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        // Walk distances 0..N-1 from the pointer; the first hit wins.
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (!any_o && req_i[k] && (k == ((int'(ptr_i) + i) % N))) begin
                    any_o    = 1'b1;
                    gnt_o[k] = 1'b1;
                    idx_o    = IW'(k);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_burst_arbiter.sv
// ============================================================================
// Module      : wb_burst_arbiter
// Description : Round-robin, burst-aware Wishbone arbiter with cycle watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_burst_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int WB_DWIDTH = 32,
    parameter int WB_AWIDTH = 32,
    parameter int TIMEOUT   = 1000
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic [N_MASTERS-1:0]               i_m_cyc,
    input  logic [N_MASTERS-1:0]               i_m_stb,
    input  logic [N_MASTERS-1:0]               i_m_we,
    input  logic [N_MASTERS-1:0]               i_m_burst,
    input  logic [N_MASTERS*WB_AWIDTH-1:0]     i_m_adr,
    input  logic [N_MASTERS*(WB_DWIDTH/8)-1:0] i_m_sel,
    input  logic [N_MASTERS*WB_DWIDTH-1:0]     i_m_dat,
    output logic [WB_DWIDTH-1:0]               o_m_dat,
    output logic [N_MASTERS-1:0]               o_m_ack,
    output logic [N_MASTERS-1:0]               o_m_err,
    output logic                               o_s_cyc,
    output logic                               o_s_stb,
    output logic                               o_s_we,
    output logic [WB_AWIDTH-1:0]               o_s_adr,
    output logic [WB_DWIDTH/8-1:0]             o_s_sel,
    output logic [WB_DWIDTH-1:0]               o_s_dat,
    input  logic [WB_DWIDTH-1:0]               i_s_dat,
    input  logic                               i_s_ack,
    input  logic                               i_s_err,
    output logic [N_MASTERS-1:0]               o_grant
);

    localparam int SW = WB_DWIDTH / 8;
    localparam int IW = idx_width(N_MASTERS);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT - 1);
    localparam logic [1:0]    BEAT_LAST = 2'(BURST_BEATS - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_MASTERS - 1);

    arb_state_e             state_q, state_d;
    logic [N_MASTERS-1:0]   grant_q, grant_d;
    logic [IW-1:0]          owner_q, owner_d;
    logic [IW-1:0]          rr_q, rr_d;
    logic [1:0]             beat_q, beat_d;
    logic [WW-1:0]          wdog_q, wdog_d;

    logic [N_MASTERS-1:0]   w_req;
    logic [N_MASTERS-1:0]   w_pick_gnt;
    logic [IW-1:0]          w_pick_idx;
    logic                   w_pick_any;
    logic                   w_pick_burst;
    logic                   w_owner_cyc;
    logic                   w_owner_stb;
    logic                   w_owner_we;
    logic                   w_active;
    logic [IW-1:0]          w_rr_next;

    assign w_req        = i_m_cyc & i_m_stb;
    assign w_pick_burst = |(i_m_burst & w_pick_gnt);
    assign w_owner_cyc  = |(i_m_cyc & grant_q);
    assign w_active     = ((state_q == ARB_SINGLE) || (state_q == ARB_BURST)) && w_owner_cyc;
    assign w_rr_next    = (owner_q == IDX_LAST) ? '0 : owner_q + IW'(1);

    wb_rr_picker #(
        .N  (N_MASTERS),
        .IW (IW)
    ) u_picker (
        .req_i (w_req),
        .ptr_i (rr_q),
        .gnt_o (w_pick_gnt),
        .idx_o (w_pick_idx),
        .any_o (w_pick_any)
    );

    // Slave-side mux; a zero grant yields an all-zero bus.
    always_comb begin
        w_owner_stb = 1'b0;
        w_owner_we  = 1'b0;
        o_s_adr     = '0;
        o_s_sel     = '0;
        o_s_dat     = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (grant_q[k]) begin
                w_owner_stb = i_m_stb[k];
                w_owner_we  = i_m_we[k];
                o_s_adr     = i_m_adr[k*WB_AWIDTH +: WB_AWIDTH];
                o_s_sel     = i_m_sel[k*SW +: SW];
                o_s_dat     = i_m_dat[k*WB_DWIDTH +: WB_DWIDTH];
            end
        end
    end

    assign o_s_cyc = w_active;
    assign o_s_stb = w_active & w_owner_stb;
    assign o_s_we  = w_active & w_owner_we;
    assign o_m_dat = i_s_dat;
    assign o_m_ack = (w_active && i_s_ack && !i_s_err) ? grant_q : '0;
    assign o_m_err = ((w_active && i_s_err) || (state_q == ARB_ABORT)) ? grant_q : '0;
    assign o_grant = grant_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        beat_d  = beat_q;
        wdog_d  = wdog_q;
        case (state_q)
            ARB_IDLE: begin
                if (w_pick_any) begin
                    grant_d = w_pick_gnt;
                    owner_d = w_pick_idx;
                    beat_d  = '0;
                    wdog_d  = '0;
                    state_d = w_pick_burst ? ARB_BURST : ARB_SINGLE;
                end
            end
            ARB_SINGLE, ARB_BURST: begin
                // Precedence: owner abandons, then err, then ack, then watchdog.
                if (!w_owner_cyc || i_s_err ||
                    (i_s_ack && ((state_q == ARB_SINGLE) || (beat_q == BEAT_LAST)))) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    rr_d    = w_rr_next;
                    beat_d  = '0;
                    wdog_d  = '0;
                end else if (i_s_ack) begin
                    beat_d  = beat_q + 2'd1;
                    wdog_d  = '0;
                end else if (wdog_q == WD_LAST) begin
                    state_d = ARB_ABORT;
                end else begin
                    wdog_d  = wdog_q + WW'(1);
                end
            end
            ARB_ABORT: begin
                state_d = ARB_IDLE;
                grant_d = '0;
                rr_d    = w_rr_next;
                beat_d  = '0;
                wdog_d  = '0;
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
            wdog_q  <= wdog_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_burst_arbiter.sv
// ============================================================================
// Module      : tb_wb_burst_arbiter
// Description : Directed scenarios plus randomized traffic against a model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_burst_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      m_cyc, m_stb, m_we, m_burst;
    logic [N*AW-1:0]   m_adr;
    logic [N*SW-1:0]   m_sel;
    logic [N*DW-1:0]   m_dat;
    logic [DW-1:0]     o_m_dat;
    logic [N-1:0]      o_m_ack, o_m_err, o_grant;
    logic              o_s_cyc, o_s_stb, o_s_we;
    logic [AW-1:0]     o_s_adr;
    logic [SW-1:0]     o_s_sel;
    logic [DW-1:0]     o_s_dat;
    logic [DW-1:0]     s_dat;
    logic              s_ack, s_err;

    wb_burst_arbiter #(
        .N_MASTERS (N),
        .WB_DWIDTH (DW),
        .WB_AWIDTH (AW),
        .TIMEOUT   (TO)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_m_cyc   (m_cyc),
        .i_m_stb   (m_stb),
        .i_m_we    (m_we),
        .i_m_burst (m_burst),
        .i_m_adr   (m_adr),
        .i_m_sel   (m_sel),
        .i_m_dat   (m_dat),
        .o_m_dat   (o_m_dat),
        .o_m_ack   (o_m_ack),
        .o_m_err   (o_m_err),
        .o_s_cyc   (o_s_cyc),
        .o_s_stb   (o_s_stb),
        .o_s_we    (o_s_we),
        .o_s_adr   (o_s_adr),
        .o_s_sel   (o_s_sel),
        .o_s_dat   (o_s_dat),
        .i_s_dat   (s_dat),
        .i_s_ack   (s_ack),
        .i_s_err   (s_err),
        .o_grant   (o_grant)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_all();
        m_cyc = '0; m_stb = '0; m_we = '0; m_burst = '0;
        m_adr = '0; m_sel = '0; m_dat = '0;
        s_dat = '0; s_ack = 1'b0; s_err = 1'b0;
    endtask

    task automatic set_m(input int k, input logic cyc, input logic burst, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat);
        m_cyc[k] = cyc; m_stb[k] = cyc; m_burst[k] = burst; m_we[k] = we;
        m_adr[k*AW +: AW] = adr;
        m_sel[k*SW +: SW] = cyc ? 4'hF : 4'h0;
        m_dat[k*DW +: DW] = dat;
    endtask

    // Precondition: current cycle is IDLE with master k the expected winner.
    task automatic single_txn(input int k, input bit drop, input string tag);
        logic [31:0] d;
        tick(); smp();
        check({tag, "_gnt"}, 32'(o_grant), 32'd1 << k);
        check({tag, "_cyc"}, 32'(o_s_cyc), 32'd1);
        check({tag, "_adr"}, o_s_adr, m_adr[k*AW +: AW]);
        tick(); d = $urandom; s_ack = 1'b1; s_dat = d; smp();
        check({tag, "_ack"}, 32'(o_m_ack), 32'd1 << k);
        check({tag, "_dat"}, o_m_dat, d);
        tick(); s_ack = 1'b0; if (drop) set_m(k, 0, 0, 0, 0, 0); smp();
        check({tag, "_gap"}, 32'(o_grant), 32'd0);
        check({tag, "_noack"}, 32'(o_m_ack), 32'd0);
    endtask

    task automatic burst_txn(input int k, input logic [31:0] base, input string tag);
        logic [31:0] d;
        int held;
        held = 1;
        tick(); smp();
        check({tag, "_gnt"}, 32'(o_grant), 32'd1 << k);
        for (int b = 0; b < 4; b++) begin
            tick(); m_adr[k*AW +: AW] = base + 32'(4 * b);
            d = $urandom; s_ack = 1'b1; s_dat = d; smp();
            check({tag, "_ack"}, 32'(o_m_ack), 32'd1 << k);
            check({tag, "_adr"}, o_s_adr, base + 32'(4 * b));
            check({tag, "_dat"}, o_m_dat, d);
            tick(); s_ack = 1'b0; if (b == 3) set_m(k, 0, 0, 0, 0, 0); smp();
            if (b < 3 && (o_s_cyc !== 1'b1 || 32'(o_grant) !== (32'd1 << k))) held = 0;
        end
        check({tag, "_held"}, held, 1);
        check({tag, "_gap"}, 32'(o_grant), 32'd0);
    endtask

    function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
        for (int i = 0; i < N; i++) begin
            int c;
            c = (ptr + i) % N;
            if (((req >> c) & 3'b001) != 0) return c;
        end
        return -1;
    endfunction

    // Randomized traffic: behavioural masters and slave, transaction-level model.
    task automatic run_random(input int cycles);
        bit          act[N], bst[N], fin[N];
        int          beat[N], gap[N];
        logic [31:0] base[N];
        bit          s_pend;
        int          s_wait;
        bit          mdl_busy, mdl_bst;
        int          mdl_own, mdl_acks, mdl_ptr;
        logic [N-1:0] req;
        for (int k = 0; k < N; k++) begin
            act[k] = 0; bst[k] = 0; fin[k] = 0; beat[k] = 0; gap[k] = 0; base[k] = 0;
        end
        s_pend = 0; s_wait = 0;
        mdl_busy = 0; mdl_bst = 0; mdl_own = 0; mdl_acks = 0; mdl_ptr = 0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            tick();
            for (int k = 0; k < N; k++) begin
                if (fin[k]) begin
                    act[k] = 0; fin[k] = 0; gap[k] = $urandom_range(0, 4);
                    set_m(k, 0, 0, 0, 0, 0);
                end
                if (!act[k]) begin
                    if (gap[k] == 0) begin
                        act[k] = 1; bst[k] = 1'($urandom_range(0, 1)); beat[k] = 0;
                        base[k] = {20'h0, 8'($urandom_range(0, 255)), 4'h0};
                        set_m(k, 1, bst[k], 1'($urandom_range(0, 1)), base[k], 0);
                    end else begin
                        gap[k]--;
                    end
                end
                if (act[k]) begin
                    m_adr[k*AW +: AW] = base[k] + 32'(4 * beat[k]);
                    m_dat[k*DW +: DW] = $urandom;
                    m_sel[k*SW +: SW] = 4'($urandom_range(1, 15));
                end
            end
            s_ack = 1'b0; s_err = 1'b0;
            if (s_pend) begin
                if (s_wait == 0) begin
                    s_err  = ($urandom_range(0, 15) == 0);
                    s_ack  = !s_err || ($urandom_range(0, 1) == 1);
                    s_dat  = $urandom;
                    s_pend = 0;
                end else begin
                    s_wait--;
                end
            end
            smp();
            req = m_cyc & m_stb;
            check("rnd_onehot", 32'($onehot0(o_grant)), 32'd1);
            if (!mdl_busy) begin
                check("rnd_idle_gnt", 32'(o_grant), 32'd0);
                check("rnd_idle_cyc", 32'(o_s_cyc), 32'd0);
                if (req != '0) begin
                    mdl_own  = rr_pick(req, mdl_ptr);
                    mdl_bst  = m_burst[mdl_own];
                    mdl_acks = 0;
                    mdl_busy = 1;
                end
            end else begin
                check("rnd_gnt", 32'(o_grant), 32'd1 << mdl_own);
                check("rnd_cyc", 32'(o_s_cyc), 32'd1);
                check("rnd_adr", o_s_adr, m_adr[mdl_own*AW +: AW]);
                check("rnd_sdat", o_s_dat, m_dat[mdl_own*DW +: DW]);
                check("rnd_sel", 32'(o_s_sel), 32'(m_sel[mdl_own*SW +: SW]));
                check("rnd_we", 32'(o_s_we), 32'(m_we[mdl_own]));
                check("rnd_ack", 32'(o_m_ack), (s_ack && !s_err) ? (32'd1 << mdl_own) : 32'd0);
                check("rnd_err", 32'(o_m_err), s_err ? (32'd1 << mdl_own) : 32'd0);
                if (s_ack && !s_err) check("rnd_mdat", o_m_dat, s_dat);
                if (s_ack || s_err) begin
                    if (!s_err) mdl_acks++;
                    if (s_err || !mdl_bst || mdl_acks == 4) begin
                        mdl_busy = 0;
                        mdl_ptr  = (mdl_own + 1) % N;
                    end
                end
            end
            for (int k = 0; k < N; k++) begin
                if (o_m_err[k]) fin[k] = 1;
                else if (o_m_ack[k]) begin
                    beat[k]++;
                    if (!bst[k] || beat[k] == 4) fin[k] = 1;
                end
            end
            if (o_s_cyc && o_s_stb && !s_ack && !s_err && !s_pend) begin
                s_pend = 1;
                s_wait = $urandom_range(0, 4);
            end
        end
    endtask

    initial begin
        int n;
        idle_all();
        rst_n = 1'b0;
        repeat (2) tick();
        check("rst_grant", 32'(o_grant), 32'd0);
        check("rst_cyc", 32'({o_s_cyc, o_s_stb, o_s_we}), 32'd0);
        check("rst_adr", o_s_adr, 32'd0);
        check("rst_ackerr", 32'({o_m_ack, o_m_err}), 32'd0);
        rst_n = 1'b1;

        // Single read on master 0
        tick(); set_m(0, 1, 0, 0, 32'h100, 0); smp();
        check("t1_idle", 32'(o_grant), 32'd0);
        tick(); smp();
        check("t1_gnt", 32'(o_grant), 32'd1);
        check("t1_cyc", 32'(o_s_cyc), 32'd1);
        check("t1_adr", o_s_adr, 32'h100);
        check("t1_we", 32'(o_s_we), 32'd0);
        tick(); smp();
        check("t1_wait", 32'(o_m_ack), 32'd0);
        tick(); s_ack = 1'b1; s_dat = 32'hDEADBEEF; smp();
        check("t1_ack", 32'(o_m_ack), 32'd1);
        check("t1_dat", o_m_dat, 32'hDEADBEEF);
        tick(); s_ack = 1'b0; set_m(0, 0, 0, 0, 0, 0); smp();
        check("t1_end_gnt", 32'(o_grant), 32'd0);
        check("t1_end_ack", 32'(o_m_ack), 32'd0);

        // Contention from reset, then owner abandons its cycle
        tick(); rst_n = 1'b0; tick(); rst_n = 1'b1;
        tick(); set_m(0, 1, 0, 0, 32'h300, 32'h11); set_m(1, 1, 0, 1, 32'h304, 32'h22); smp();
        check("t2_idle", 32'(o_grant), 32'd0);
        single_txn(0, 0, "t2_a");
        single_txn(1, 0, "t2_b");
        single_txn(0, 0, "t2_c");
        single_txn(1, 1, "t2_d");
        tick(); set_m(0, 0, 0, 0, 0, 0); smp();
        check("t2_drop_cyc", 32'(o_s_cyc), 32'd0);
        check("t2_drop_ackerr", 32'({o_m_ack, o_m_err}), 32'd0);
        tick(); smp();
        check("t2_drop_idle", 32'(o_grant), 32'd0);

        // Burst hold: m1 burst wins (pointer at 1) while m0 waits
        tick(); set_m(1, 1, 1, 1, 32'h200, 32'hA0); set_m(0, 1, 0, 0, 32'h400, 0); smp();
        burst_txn(1, 32'h200, "t3");
        single_txn(0, 1, "t3_m0");

        // Watchdog abort on m2, then m0 served
        tick(); set_m(2, 1, 0, 0, 32'h500, 0); smp();
        tick(); set_m(0, 1, 0, 0, 32'h600, 0); smp();
        check("t4_gnt", 32'(o_grant), 32'd4);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            tick(); smp();
            if (o_s_cyc) n++;
            else break;
        end
        check("t4_len", n, TO);
        check("t4_err", 32'(o_m_err), 32'd4);
        tick(); set_m(2, 0, 0, 0, 0, 0); smp();
        check("t4_err_once", 32'(o_m_err), 32'd0);
        check("t4_idle", 32'(o_grant), 32'd0);
        single_txn(0, 1, "t4_next");

        // Error (with simultaneous ack) on beat 2 of an m1 burst
        tick(); set_m(1, 1, 1, 0, 32'h700, 0); smp();
        tick(); smp();
        check("t5_gnt", 32'(o_grant), 32'd2);
        tick(); s_ack = 1'b1; smp();
        check("t5_ack1", 32'(o_m_ack), 32'd2);
        tick(); s_ack = 1'b0; smp();
        tick(); s_ack = 1'b1; s_err = 1'b1; smp();
        check("t5_err", 32'(o_m_err), 32'd2);
        check("t5_err_noack", 32'(o_m_ack), 32'd0);
        tick(); s_ack = 1'b0; s_err = 1'b0; set_m(1, 0, 0, 0, 0, 0); smp();
        check("t5_idle", 32'(o_grant), 32'd0);
        check("t5_err_once", 32'(o_m_err), 32'd0);
        tick(); set_m(1, 1, 1, 0, 32'h800, 0); smp();
        burst_txn(1, 32'h800, "t5_full");

        // Asynchronous reset in the middle of an m0 burst
        tick(); set_m(0, 1, 1, 0, 32'h900, 0); smp();
        tick(); smp();
        check("t6_gnt", 32'(o_grant), 32'd1);
        tick(); s_ack = 1'b1; smp();
        check("t6_ack", 32'(o_m_ack), 32'd1);
        tick(); s_ack = 1'b0;
        check("t6_pre_cyc", 32'(o_s_cyc), 32'd1);
        #2; rst_n = 1'b0; #1;
        check("t6_rst_cyc", 32'(o_s_cyc), 32'd0);
        check("t6_rst_gnt", 32'(o_grant), 32'd0);
        check("t6_rst_adr", o_s_adr, 32'd0);
        idle_all();
        tick(); rst_n = 1'b1;
        tick(); set_m(1, 1, 0, 0, 32'hA00, 0); smp();
        check("t6_post_idle", 32'(o_grant), 32'd0);
        single_txn(1, 1, "t6_post");

        // Randomized traffic from a fresh reset
        tick(); idle_all(); rst_n = 1'b0; tick(); rst_n = 1'b1;
        run_random(2000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
